// File: rtl/biquad_tdm.sv
// biquad_tdm: time-multiplexed multi-channel biquad section. One shared MAC serves every
// channel of a frame. Coefficients are double-buffered and swapped only when a frame is accepted.

module biquad_tdm_lane #(
  parameter int DW = 16
) (
  input  logic          clk_48,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [DW-1:0] x0_i,
  input  logic [DW-1:0] y_i,
  input  logic          sat_i,
  output logic [DW-1:0] x1_o,
  output logic [DW-1:0] x2_o,
  output logic [DW-1:0] y1_o,
  output logic [DW-1:0] y2_o,
  output logic [DW-1:0] out_o,
  output logic          sat_o
);
  logic [DW-1:0] x1_q, x2_q, y1_q, y2_q, out_q;
  logic          sat_q;

  // A history clear leaves the output slot and the saturation flag untouched.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      x1_q  <= '0;
      x2_q  <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      x1_q <= '0;
      x2_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
    end else if (wr_i) begin
      x2_q  <= x1_q;
      x1_q  <= x0_i;
      y2_q  <= y1_q;
      y1_q  <= y_i;
      out_q <= y_i;
      sat_q <= sat_i;
    end
  end

  assign x1_o  = x1_q;
  assign x2_o  = x2_q;
  assign y1_o  = y1_q;
  assign y2_o  = y2_q;
  assign out_o = out_q;
  assign sat_o = sat_q;
endmodule

module biquad_tdm #(
  parameter int CHANNELS = 2,
  parameter int DW       = 16,
  parameter int CW       = 32,
  parameter int FRAC     = 30,
  parameter int ACCW     = 64
) (
  input  logic                   clk_48,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*DW-1:0] in_data,
  input  logic                   coef_we,
  input  logic [2:0]             coef_addr,
  input  logic [CW-1:0]          coef_data,
  input  logic                   coef_commit,
  input  logic                   hist_clr,
  output logic                   out_valid,
  output logic [CHANNELS*DW-1:0] out_data,
  output logic [CHANNELS-1:0]    sat_flag
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0]         UNITY = CW'(1) << FRAC;
  localparam logic [4:0][CW-1:0]    PASS  = {{(4*CW){1'b0}}, UNITY};
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC-1);
  localparam logic signed [ACCW-1:0] YMAX = (ACCW'(1) << (DW-1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] YMIN = -(ACCW'(1) << (DW-1));

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_e;

  state_e                         state_q, state_d;
  logic [CHW-1:0]                 ch_q, ch_d;
  logic [2:0]                     k_q, k_d;
  logic signed [ACCW-1:0]         acc_q, acc_d;
  logic [4:0][CW-1:0]             shad_q, shad_d, act_q, act_d;
  logic                           cpend_q, cpend_d, hpend_q, hpend_d;
  logic                           commit_now, clr_now, accept;
  logic [CHANNELS-1:0][DW-1:0]    xin_q, xin_d, x1_w, x2_w, y1_w, y2_w, out_w;
  logic [CHANNELS-1:0]            wr_w, sat_w;
  logic signed [CW-1:0]           coef_sel;
  logic signed [DW-1:0]           samp_sel;
  logic signed [DW+CW-1:0]        prod;
  logic signed [ACCW-1:0]         shr;
  logic signed [DW-1:0]           y_sat;
  logic                           clip;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready & in_valid;

  // Shadow bank and sticky requests; a same-cycle write is part of the swapped set.
  always_comb begin
    shad_d = shad_q;
    if (coef_we && coef_addr <= 3'd4) shad_d[coef_addr] = coef_data;
    commit_now = cpend_q | coef_commit;
    clr_now    = hpend_q | hist_clr;
    act_d      = act_q;
    cpend_d    = commit_now;
    hpend_d    = clr_now;
    if (accept) begin
      if (commit_now) act_d = shad_d;
      cpend_d = 1'b0;
      hpend_d = 1'b0;
    end
  end

  always_comb begin
    coef_sel = '0;
    samp_sel = '0;
    case (k_q)
      3'd0: begin coef_sel = act_q[0]; samp_sel = xin_q[ch_q]; end
      3'd1: begin coef_sel = act_q[1]; samp_sel = x1_w[ch_q];  end
      3'd2: begin coef_sel = act_q[2]; samp_sel = x2_w[ch_q];  end
      3'd3: begin coef_sel = act_q[3]; samp_sel = y1_w[ch_q];  end
      3'd4: begin coef_sel = act_q[4]; samp_sel = y2_w[ch_q];  end
      default: ;
    endcase
    prod = coef_sel * samp_sel;
  end

  // Round half up, then clip to the DW-bit range.
  always_comb begin
    shr   = (acc_q + HALF) >>> FRAC;
    clip  = 1'b0;
    y_sat = shr[DW-1:0];
    if (shr > YMAX) begin
      y_sat = YMAX[DW-1:0];
      clip  = 1'b1;
    end else if (shr < YMIN) begin
      y_sat = YMIN[DW-1:0];
      clip  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    k_d     = k_q;
    acc_d   = acc_q;
    xin_d   = xin_q;
    wr_w    = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        xin_d   = in_data;
        ch_d    = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = ((k_q == 3'd0) ? ACCW'(0) : acc_q) + ACCW'(prod);
        k_d   = k_q + 3'd1;
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_w[ch_q] = 1'b1;
        if (ch_q == CHW'(CHANNELS-1)) state_d = DONE;
        else begin
          ch_d    = ch_q + CHW'(1);
          state_d = MAC;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      xin_q   <= '0;
      shad_q  <= PASS;
      act_q   <= PASS;
      cpend_q <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      xin_q   <= xin_d;
      shad_q  <= shad_d;
      act_q   <= act_d;
      cpend_q <= cpend_d;
      hpend_q <= hpend_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    biquad_tdm_lane #(.DW(DW)) u_lane (
      .clk_48  (clk_48),
      .reset_n (reset_n),
      .clr_i   (accept & clr_now),
      .wr_i    (wr_w[i]),
      .x0_i    (xin_q[i]),
      .y_i     (y_sat),
      .sat_i   (clip),
      .x1_o    (x1_w[i]),
      .x2_o    (x2_w[i]),
      .y1_o    (y1_w[i]),
      .y2_o    (y2_w[i]),
      .out_o   (out_w[i]),
      .sat_o   (sat_w[i])
    );
  end

  assign out_data = out_w;
  assign sat_flag = sat_w;
endmodule

// File: tb/tb_biquad_tdm.sv
// Bench for biquad_tdm: directed cases plus random frames against a frame-level arithmetic model.
module tb_biquad_tdm;
  localparam int CH = 2, DW = 16, CW = 32, FRAC = 30, ACCW = 64;
  localparam int LAT = 6*CH + 1;
  localparam longint YMAX = (longint'(1) <<< (DW-1)) - 1;
  localparam longint YMIN = -(longint'(1) <<< (DW-1));

  logic clk_48 = 1'b0, reset_n = 1'b0, in_valid = 1'b0;
  logic coef_we = 1'b0, coef_commit = 1'b0, hist_clr = 1'b0;
  logic [CH*DW-1:0] in_data = '0;
  logic [2:0]       coef_addr = '0;
  logic [CW-1:0]    coef_data = '0;
  logic             in_ready, out_valid;
  logic [CH*DW-1:0] out_data;
  logic [CH-1:0]    sat_flag;

  int errs = 0, checks = 0;

  always #5 clk_48 = ~clk_48;

  biquad_tdm #(.CHANNELS(CH), .DW(DW), .CW(CW), .FRAC(FRAC), .ACCW(ACCW)) dut (
    .clk_48(clk_48), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .hist_clr(hist_clr), .out_valid(out_valid),
    .out_data(out_data), .sat_flag(sat_flag)
  );

  // Reference state: shadow/active coefficient sets, pending requests, per-channel history.
  longint sh[5], ac[5];
  bit     cp, hp;
  longint xin[CH], mx1[CH], mx2[CH], my1[CH], my2[CH], ey[CH];
  logic [CH-1:0] esat;
  longint got[CH];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin sh[i] = 0; ac[i] = 0; end
    sh[0] = longint'(1) <<< FRAC;
    ac[0] = sh[0];
    cp = 0; hp = 0; esat = '0;
    for (int k = 0; k < CH; k++) begin
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; ey[k] = 0;
    end
  endfunction

  function automatic void model_frame();
    longint acc, y;
    if (cp) begin
      for (int i = 0; i < 5; i++) ac[i] = sh[i];
      cp = 0;
    end
    if (hp) begin
      for (int k = 0; k < CH; k++) begin mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; end
      hp = 0;
    end
    for (int k = 0; k < CH; k++) begin
      acc = ac[0]*xin[k] + ac[1]*mx1[k] + ac[2]*mx2[k] + ac[3]*my1[k] + ac[4]*my2[k];
      y = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
      esat[k] = (y > YMAX) || (y < YMIN);
      if (y > YMAX) y = YMAX;
      else if (y < YMIN) y = YMIN;
      mx2[k] = mx1[k]; mx1[k] = xin[k];
      my2[k] = my1[k]; my1[k] = y;
      ey[k] = y;
    end
  endfunction

  task automatic wcoef(input int a, input longint v);
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = v[CW-1:0];
    @(negedge clk_48);
    coef_we = 1'b0;
    if (a < 5) sh[a] = v;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    @(negedge clk_48);
    coef_commit = 1'b0;
    cp = 1;
  endtask

  task automatic hclear();
    hist_clr = 1'b1;
    @(negedge clk_48);
    hist_clr = 1'b0;
    hp = 1;
  endtask

  task automatic drive_in();
    longint v;
    for (int k = 0; k < CH; k++) begin
      v = xin[k];
      in_data[k*DW +: DW] = v[DW-1:0];
    end
  endtask

  // One frame; optionally writes b0 together with a commit while the frame is in flight.
  task automatic send(input bit mid, input longint midv);
    int n, lat;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk_48); n++; end
    chk("ready_wait", in_ready, 1);
    drive_in();
    in_valid = 1'b1;
    model_frame();
    @(negedge clk_48);
    in_valid = 1'b0;
    lat = 1;
    chk("busy_not_ready", in_ready, 0);
    while (!out_valid && lat < 100) begin
      if (mid && lat == 2) begin
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = midv[CW-1:0]; coef_commit = 1'b1;
      end else begin
        coef_we = 1'b0; coef_commit = 1'b0;
      end
      @(negedge clk_48);
      lat++;
    end
    coef_we = 1'b0; coef_commit = 1'b0;
    if (mid) begin sh[0] = midv; cp = 1; end
    chk("latency", lat, LAT);
    for (int k = 0; k < CH; k++) begin
      got[k] = longint'($signed(out_data[k*DW +: DW]));
      chk($sformatf("out_ch%0d", k), $signed(out_data[k*DW +: DW]), ey[k]);
    end
    chk("sat_flag", sat_flag, esat);
    @(negedge clk_48);
    chk("out_valid_pulse", out_valid, 0);
  endtask

  initial begin
    int pulses;
    longint fb[4];
    model_reset();
    repeat (2) @(negedge clk_48);
    chk("rst_out_valid", out_valid, 0);
    reset_n = 1'b1;
    @(negedge clk_48);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid2", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat", sat_flag, 0);

    // Passthrough from reset coefficients
    xin[0] = 1000; xin[1] = -2000;
    send(0, 0);
    chk("pass_ch0", got[0], 1000);
    chk("pass_ch1", got[1], -2000);

    // Impulse through an FIR of three quarter taps; ch1 idle
    wcoef(0, 1 <<< 28); wcoef(1, 1 <<< 28); wcoef(2, 1 <<< 28);
    commit(); hclear();
    fb = '{1000, 1000, 1000, 0};
    for (int f = 0; f < 4; f++) begin
      xin[0] = (f == 0) ? 4000 : 0; xin[1] = 0;
      send(0, 0);
      chk($sformatf("imp_ch0_%0d", f), got[0], fb[f]);
      chk($sformatf("imp_ch1_%0d", f), got[1], 0);
    end

    // Saturation at both rails with gain 1.5
    wcoef(0, 3 * (longint'(1) <<< 29)); wcoef(1, 0); wcoef(2, 0);
    commit(); hclear();
    xin[0] = 30000; xin[1] = -30000;
    send(0, 0);
    chk("sat_hi", got[0], 32767);
    chk("sat_lo", got[1], -32768);
    chk("sat_bits", sat_flag, 2'b11);
    xin[0] = 100; xin[1] = 0;
    send(0, 0);
    chk("sat_cleared", sat_flag, 2'b00);

    // Recursive term: y = x + 0.5*y1
    wcoef(0, longint'(1) <<< 30); wcoef(3, longint'(1) <<< 29);
    commit(); hclear();
    fb = '{1000, 1500, 1750, 1875};
    for (int f = 0; f < 4; f++) begin
      xin[0] = 1000; xin[1] = 0;
      send(0, 0);
      chk($sformatf("fb_%0d", f), got[0], fb[f]);
    end

    // Mid-frame write+commit takes effect only on the next frame
    wcoef(3, 0); wcoef(0, longint'(1) <<< 30);
    commit(); hclear();
    xin[0] = 1000; xin[1] = 1000;
    send(1, longint'(1) <<< 29);
    chk("commit_cur", got[0], 1000);
    send(0, 0);
    chk("commit_next0", got[0], 500);
    chk("commit_next1", got[1], 500);

    // Random coefficients, samples and history clears
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int a = 0; a < 3; a++) wcoef(a, longint'($urandom_range(0, 32'h7fff_ffff)) - (longint'(1) <<< 30));
        for (int a = 3; a < 5; a++) wcoef(a, longint'($urandom_range(0, 32'h4000_0000)) - (longint'(1) <<< 29));
        wcoef(int'($urandom_range(5, 7)), longint'($urandom));
        commit();
      end
      if ($urandom_range(0, 4) == 0) hclear();
      for (int k = 0; k < CH; k++) xin[k] = longint'($urandom_range(0, 65535)) - 32768;
      send(0, 0);
    end

    // in_valid held while busy: one frame only
    @(negedge clk_48);
    for (int k = 0; k < CH; k++) xin[k] = longint'($urandom_range(0, 2000)) - 1000;
    drive_in();
    in_valid = 1'b1;
    model_frame();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk_48); if (out_valid) pulses++; end
    in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_48);
      if (out_valid) begin
        pulses++;
        for (int k = 0; k < CH; k++) chk($sformatf("bp_ch%0d", k), $signed(out_data[k*DW +: DW]), ey[k]);
      end
    end
    chk("bp_pulses", pulses, 1);

    // Reset mid-MAC
    xin[0] = 7; xin[1] = 9;
    drive_in();
    in_valid = 1'b1;
    @(negedge clk_48);
    in_valid = 1'b0;
    repeat (3) @(negedge clk_48);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_sat", sat_flag, 0);
    @(negedge clk_48);
    reset_n = 1'b1;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk_48); if (out_valid) pulses++; end
    chk("mid_rst_no_valid", pulses, 0);
    xin[0] = 1234; xin[1] = -5678;
    send(0, 0);
    chk("rst_pass_ch0", got[0], 1234);
    chk("rst_pass_ch1", got[1], -5678);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/biquad_tdm.md
# biquad_tdm

Multi-channel, time-multiplexed second-order IIR (biquad) section for the channel-strip audio path. One shared signed multiplier-accumulator processes every channel of a sample frame in sequence, with per-channel history registers. Coefficients are loaded through a double-buffered register bank and swapped only at a frame boundary, so tone changes are glitch-free. It replaces the fixed-table lowpass/EQ stages and sits between the audio codec input deserialiser and the output mixer.

## Interface
- CHANNELS, 2, number of audio channels per frame (1..8)
- DW, 16, sample width, signed two's complement
- CW, 32, coefficient width, signed
- FRAC, 30, fractional bits of coefficients (Q(CW-FRAC).FRAC)
- ACCW, 64, accumulator width; must be ≥ DW+CW+3

- clk_48  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame
- in_data  in  CHANNELS*DW  frame; channel k at bits [k*DW +: DW]
- coef_we  in  1  write one shadow coefficient
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored
- coef_data  in  CW  coefficient value
- coef_commit  in  1  request shadow→active swap
- hist_clr  in  1  zero all channel histories at next frame boundary
- out_valid  out  1  one-cycle pulse, output frame ready
- out_data  out  CHANNELS*DW  filtered frame, same packing as in_data
- sat_flag  out  CHANNELS  per-channel: output saturated in this frame

## Operation
- Difference equation per channel: y = b0·x0 + b1·x1 + b2·x2 + a1·y1 + a2·y2 (a1/a2 stored with the sign already applied, i.e. added).
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: in_ready=1. On in_valid: latch in_data, apply pending commit/clear (see below), channel index ch=0, → MAC.
- MAC: 5 cycles, one product per cycle in order b0·x0, b1·x1, b2·x2, a1·y1, a2·y2; each product (DW+CW bits, sign-extended) added into ACCW accumulator cleared at the first term.
- WRITE: result = (acc + 2^(FRAC-1)) >>> FRAC (round half up); saturate to [-2^(DW-1), 2^(DW-1)-1]; set sat_flag[ch] if clipped. Update ch history: x2←x1, x1←x0_in, y2←y1, y1←saturated result. Store result in out_data slot ch. If ch<CHANNELS-1: ch+1, → MAC; else → DONE.
- DONE: out_valid=1 for one cycle, → IDLE.
- Histories stored at DW bits (saturated values only).
- Coefficients: coef_we writes the shadow bank any cycle. coef_commit sets a sticky pending bit; swap happens in IDLE on the frame-accept cycle, before the first MAC, so every channel of a frame uses one coefficient set. hist_clr likewise sticky, applied at the same point, zeroing x1,x2,y1,y2 of all channels.
- coef_commit and coef_we in same cycle: write lands in shadow first and is included in the swap.
- Commit pending with no in_valid: swap waits; shadow remains writable.

## Timing
- Reset: in_ready=1 (state IDLE), out_valid=0, out_data=0, sat_flag=0, all histories 0, pending bits 0; active and shadow banks = passthrough (b0=2^FRAC, others 0).
- Latency in_valid&in_ready → out_valid: 6·CHANNELS+1 cycles (CHANNELS=2: 13).
- in_ready=0 from cycle after accept until state returns to IDLE; in_valid while not ready is ignored (upstream holds). Max throughput one frame per 6·CHANNELS+2 cycles.
- out_data and sat_flag hold their values until the next frame's WRITE updates each slot.
- Reset asserted mid-frame: immediate return to reset state; partial frame discarded, no out_valid.

## Test plan
- Reset defaults, passthrough: frame (1000, -2000) → out (1000, -2000) after 13 cycles, sat_flag=00.
- Impulse with b0=b1=b2=0.25 (2^28), a=0: inputs 4000,0,0,0 on ch0 → 1000,1000,1000,0; ch1 fed 0 stays 0 (channel independence).
- Saturation: b0=2.0 (2^31 needs CW headroom; use b0=1.5), input 30000 → out 32767, sat_flag[0]=1; input -30000 → -32768.
- Feedback: b0=1.0, a1=0.5 (2^29), step 1000 → 1000,1500,1750,1875 (rounded).
- Commit timing: write new b0 and pulse coef_commit mid-frame → current frame unchanged, next frame uses new b0; simultaneous coef_we+coef_commit captured.
- Backpressure and reset: in_valid held during busy → exactly one frame accepted; reset_n pulsed mid-MAC → no out_valid, outputs 0, passthrough restored.
